rr_onehot_arbiter: RTL
======================

Name: rr_onehot_arbiter

Overview:
- 8-requester round-robin arbiter directly upstream of the 8-to-3 one-hot encoder.
- Registers a strictly one-hot grant vector that drives the encoder's input.
- Holds each grant under a valid/ready handshake until the consumer accepts it.
- Guarantees the encoder never sees a zero or multi-hot vector while gnt_valid is high.

Parameters:
- N, 8, number of requesters; only 8 is supported, the encoder width is fixed.
- PTR_W, 3, priority-pointer width, log2(N).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, 8, request lines; bit i means requester i wants service.
- mask, input, 8, per-requester enable; a requester is eligible only when req[i]&mask[i].
- gnt, output, 8, registered one-hot grant; all-zero when gnt_valid=0.
- gnt_valid, output, 1, gnt holds a valid grant.
- gnt_ready, input, 1, downstream accepts the grant this cycle.
- ptr, output, 3, current highest-priority index, for debug and verification.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - gnt=8'h00, gnt_valid=0, ptr=0, state=IDLE.
  - Takes effect immediately, including mid-grant; any held grant is dropped without handshake.
- Eligible vector: elig = req & mask, sampled at the rising edge.
- Winner: the first set bit of elig scanning ptr, ptr+1, ..., ptr+7, indices modulo 8 (wrap 7->0).
- States:
  - IDLE: gnt_valid=0, gnt=0. If elig!=0 at the edge, load gnt=onehot(winner), set gnt_valid=1, go to GRANT. Else stay in IDLE.
  - GRANT: gnt and gnt_valid are held stable while gnt_ready=0. The grant is NOT withdrawn if the granted req or mask bit drops; once a grant is issued it completes.
  - Handshake (gnt_valid&gnt_ready at the edge):
    - ptr <= (granted index + 1) mod 8.
    - The next winner is computed in the same cycle from the current elig, using the updated pointer value.
    - If elig is nonzero: load the new grant and stay in GRANT. Zero bubble, back-to-back grants.
    - Else: go to IDLE, gnt<=0, gnt_valid<=0.
- Latency: elig rising in IDLE at edge k gives gnt_valid=1 after edge k; earliest handshake at edge k+1.
- A requester that is still requesting may be re-granted immediately only if it is the sole eligible requester.
- Fairness: with all 8 requesting continuously and gnt_ready=1, grants cycle 0,1,...,7,0 with period 8.
- ptr changes only on a handshake; it never changes in IDLE or while stalled.
- gnt_ready while gnt_valid=0 is ignored.
- Invariant: gnt_valid=1 implies exactly one bit of gnt is set; gnt_valid=0 implies gnt=0.

Test Plan:
- Reset mid-grant:
  - Stimulus: hold req=8'h10, gnt_ready=0, so gnt=8'h10 and gnt_valid=1; then pulse rst_n low asynchronously between edges.
  - Required response: gnt=0, gnt_valid=0, ptr=0 immediately. After release with req=8'h10, gnt=8'h10 one cycle later.
- Round-robin sweep:
  - Stimulus: req=8'hFF, mask=8'hFF, gnt_ready=1 constantly.
  - Required response: gnt sequence 01,02,04,08,10,20,40,80,01 on consecutive cycles; ptr follows 1,2,...,7,0.
- Wrap and priority:
  - Stimulus: ptr=6 (reach it via prior grant of index 5), then req=8'h05.
  - Required response: gnt=8'h01 (index 0, wrap past 6,7), then ptr=1; next grant is 8'h04.
- Stall and hold:
  - Stimulus: req=8'h08, gnt_ready=0 for 5 cycles; req drops to 0 on cycle 2; gnt_ready=1 on cycle 6.
  - Required response: gnt=8'h08 stable for all cycles; handshake at cycle 6, then IDLE with gnt=0 and ptr=4.
- Mask:
  - Stimulus: req=8'hFF, mask=8'hA0, gnt_ready=1.
  - Required response: grants alternate 8'h20, 8'h80; never any other bit.
- Sole requester and encoder chain:
  - Stimulus: req=8'h40, gnt_ready=1.
  - Required response: gnt=8'h40 every cycle with no bubble; the encoder output fed from gnt equals 3'b110 whenever gnt_valid=1.
  - The one-hot invariant is checked by assertion on every cycle of every test.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// Eight-way round-robin arbiter feeding an 8-to-3 one-hot encoder.
// Each grant is registered strictly one-hot and is held under valid/ready until it is accepted.
module rr_onehot_arbiter #(
    parameter int N     = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [PTR_W-1:0] ptr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [N-1:0]     gnt_q;
    logic             gntValid_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gntIdx_q;

    logic [N-1:0]     elig;
    logic             handshake;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] scanPtr;
    logic [PTR_W-1:0] winIdx;
    logic             winFound;
    logic [N-1:0]     winOneHot;

    assign elig      = req & mask;
    assign handshake = (state_q == GRANT) && gnt_ready;
    assign ptr_d     = gntIdx_q + PTR_W'(1);

    // On a handshake the next winner is already searched from the advanced pointer.
    assign scanPtr   = handshake ? ptr_d : ptr_q;

    always_comb begin
        winIdx   = '0;
        winFound = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!winFound && elig[scanPtr + PTR_W'(k)]) begin
                winIdx   = scanPtr + PTR_W'(k);
                winFound = 1'b1;
            end
        end
    end

    assign winOneHot = N'(1) << winIdx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gntValid_q <= 1'b0;
            ptr_q      <= '0;
            gntIdx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winFound) begin
                        gnt_q      <= winOneHot;
                        gntValid_q <= 1'b1;
                        gntIdx_q   <= winIdx;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    // The grant is held even if its request or mask bit drops.
                    if (gnt_ready) begin
                        ptr_q <= ptr_d;
                        if (winFound) begin
                            gnt_q    <= winOneHot;
                            gntIdx_q <= winIdx;
                        end else begin
                            gnt_q      <= '0;
                            gntValid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: begin
                    gnt_q      <= '0;
                    gntValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gntValid_q;
    assign ptr       = ptr_q;

endmodule
